// File: rtl/serial_subtractor_16.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT_W bits per cycle, with
// borrow-out and two's-complement overflow, valid/ready on both sides.
module serial_subtractor_16 #(
  parameter int DATA_W  = 16,
  parameter int DIGIT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              bin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] diff,
  output logic              bout,
  output logic              ovf,
  output logic              busy
);

  localparam int N     = DATA_W / DIGIT_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if ((DATA_W % DIGIT_W) != 0) begin : g_bad_digit_w
      $error("serial_subtractor_16: DATA_W must be a multiple of DIGIT_W");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [CNT_W-1:0]          r_cnt;
  logic [DATA_W-1:0]         r_a;
  logic [DATA_W-1:0]         r_b;
  logic [DATA_W-1:0]         r_res;
  logic [DATA_W-1:0]         r_diff;
  logic                      r_borrow;
  logic                      r_bout;
  logic                      r_ovf;
  logic                      r_a_msb;
  logic                      r_b_msb;
  logic [DIGIT_W:0]          w_sub;
  logic [DATA_W+DIGIT_W-1:0] w_cat;
  logic [DATA_W-1:0]         w_res_next;
  logic                      w_last;
  logic                      w_accept;
  logic                      w_release;

  // One digit of a - b - borrow; the top bit of the result is the borrow-out.
  function automatic logic [DIGIT_W:0] digit_sub(input logic [DIGIT_W-1:0] x,
                                                 input logic [DIGIT_W-1:0] y,
                                                 input logic               bw);
    return {1'b0, x} - {1'b0, y} - {{DIGIT_W{1'b0}}, bw};
  endfunction

  function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                   input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;

  assign w_accept   = in_valid & in_ready;
  assign w_release  = out_valid & out_ready;
  assign w_last     = (r_cnt == CNT_W'(N - 1));
  assign w_sub      = digit_sub(r_a[DIGIT_W-1:0], r_b[DIGIT_W-1:0], r_borrow);
  // New digit enters at the MSB end; after N cycles the first digit sits at the LSB.
  assign w_cat      = {w_sub[DIGIT_W-1:0], r_res};
  assign w_res_next = w_cat[DATA_W+DIGIT_W-1:DIGIT_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (w_release) w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_a_msb  <= a[DATA_W-1];
            r_b_msb  <= b[DATA_W-1];
            r_cnt    <= '0;
          end
        end
        S_RUN: begin
          r_a      <= r_a >> DIGIT_W;
          r_b      <= r_b >> DIGIT_W;
          r_borrow <= w_sub[DIGIT_W];
          r_res    <= w_res_next;
          r_cnt    <= w_last ? '0 : r_cnt + CNT_W'(1);
          // Outputs load on the same edge that enters DONE.
          if (w_last) begin
            r_diff <= w_res_next;
            r_bout <= w_sub[DIGIT_W];
            r_ovf  <= sub_ovf(r_a_msb, r_b_msb, w_res_next[DATA_W-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_16.sv
// Directed and random bench for serial_subtractor_16 at default parameters.
module tb_serial_subtractor_16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  serial_subtractor_16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: 17-bit subtraction gives borrow in bit 16.
  function automatic logic [17:0] ref_sub(input logic [15:0] ra, input logic [15:0] rb,
                                          input logic rbin);
    logic [16:0] t;
    logic        ov;
    t  = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
    ov = (ra[15] != rb[15]) && (t[15] != ra[15]);
    return {ov, t[16], t[15:0]};
  endfunction

  // Issues one operation with out_ready high and checks latency, result and release.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                        input logic [15:0] ed, input logic eb, input logic eo,
                        input string nm);
    int lat;
    int w;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_vec++;
    if (!in_ready) begin
      n_err++;
      $display("FAIL %s_ready_wait: in_ready=%0b required 1", nm, in_ready);
    end
    a = ta; b = tb_; bin = tbin; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; bin = 1'b1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (lat !== 4) begin
      n_err++;
      $display("FAIL %s_latency: got %0d edges required 4", nm, lat);
    end
    n_vec++;
    if (diff !== ed) begin
      n_err++;
      $display("FAIL %s_diff: got %h required %h", nm, diff, ed);
    end
    n_vec++;
    if (bout !== eb) begin
      n_err++;
      $display("FAIL %s_bout: got %0b required %0b", nm, bout, eb);
    end
    n_vec++;
    if (ovf !== eo) begin
      n_err++;
      $display("FAIL %s_ovf: got %0b required %0b", nm, ovf, eo);
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_release: out_valid=%0b in_ready=%0b required 0/1", nm, out_valid,
               in_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = ~in_valid; out_ready = ~out_ready;
      a = 16'h1111 * (i + 1); b = 16'h0F0F; bin = ~bin;
    end
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: in_ready=%0b out_valid=%0b busy=%0b required 1/0/0",
               in_ready, out_valid, busy);
    end
    n_vec++;
    if (diff !== 16'h0000 || bout !== 1'b0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_data: diff=%h bout=%0b ovf=%0b required 0000/0/0", diff, bout, ovf);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_borrow;
    run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, "zero_minus_one");
    run_op(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, "equal_bin");
  endtask

  task automatic test_overflow;
    run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, "minneg_minus_pos");
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, "maxpos_minus_neg1");
  endtask

  task automatic test_reset_mid_run;
    logic seen;
    @(negedge clk);
    a = 16'h1234; b = 16'h0001; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_reset_ctrl: in_ready=%0b out_valid=%0b busy=%0b required 1/0/0",
               in_ready, out_valid, busy);
    end
    n_vec++;
    if (diff !== 16'h0000 || bout !== 1'b0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_reset_data: diff=%h bout=%0b ovf=%0b required 0000/0/0",
               diff, bout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_no_output: out_valid seen=%0b required 0", seen);
    end
  endtask

  task automatic test_backpressure;
    int w;
    @(negedge clk);
    a = 16'h00FF; b = 16'h0F0F; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || diff !== 16'hF1F0 || bout !== 1'b1 || ovf !== 1'b0 ||
          in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL backpressure_hold[%0d]: out_valid=%0b diff=%h bout=%0b ovf=%0b in_ready=%0b required 1/F1F0/1/0/0",
                 i, out_valid, diff, bout, ovf, in_ready);
      end
      in_valid = ~in_valid; a = 16'hAAAA ^ 16'(i); b = 16'h5555; bin = i[0];
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || diff !== 16'hF1F0) begin
      n_err++;
      $display("FAIL backpressure_release: out_valid=%0b in_ready=%0b busy=%0b diff=%h required 0/1/0/F1F0",
               out_valid, in_ready, busy, diff);
    end
  endtask

  task automatic test_back_to_back;
    logic [17:0] exp_q[$];
    logic [17:0] e;
    int sent;
    int got;
    int cyc;
    sent = 0; got = 0; cyc = 0;
    while (got < 1000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_extra: result %h arrived with none outstanding", diff);
        end else begin
          e = exp_q.pop_front();
          if ({ovf, bout, diff} !== e) begin
            n_err++;
            $display("FAIL b2b_result[%0d]: got ovf=%0b bout=%0b diff=%h required ovf=%0b bout=%0b diff=%h",
                     got, ovf, bout, diff, e[17], e[16], e[15:0]);
          end
        end
        got++;
      end
      in_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
      a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_sub(a, b, bin));
        sent++;
      end
    end
    in_valid = 1'b0;
    n_vec++;
    if (got !== 1000 || exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL b2b_count: received %0d outstanding %0d required 1000/0", got,
               exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_borrow;
    test_overflow;
    test_reset_mid_run;
    test_backpressure;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor_16.md
Name: serial_subtractor_16

Overview:
- Multi-cycle digit-serial subtractor: diff = a - b - bin over DATA_W bits, with borrow-out and signed-overflow flags.
- Companion and inverse of the team's 16-bit ripple-carry adder in the arith netlist set.
- Processes DIGIT_W bits per cycle; valid/ready handshake on the operand side and the result side.
- Used where area matters more than latency, and as a sequential benchmark alongside the combinational adder.

Parameters:
- DATA_W, 16, operand and result width in bits.
- DIGIT_W, 4, bits processed per RUN cycle. DATA_W must be an integer multiple of DIGIT_W; an elaboration-time check enforces this.
- N (derived), DATA_W/DIGIT_W, number of RUN cycles (4 at defaults).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset; deassertion synchronised externally.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept operands.
- a  in  DATA_W  minuend.
- b  in  DATA_W  subtrahend.
- bin  in  1  borrow-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- diff  out  DATA_W  a - b - bin, modulo 2^DATA_W.
- bout  out  1  borrow-out: 1 iff unsigned a < b + bin.
- ovf  out  1  two's-complement overflow of the subtraction.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; diff=0; bout=0; ovf=0; busy=0; digit counter, borrow and operand shift registers cleared. An in-flight operation is discarded with no output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture a, b, bin into internal registers; counter=0; go to RUN.
  - a/b/bin are sampled only on this handshake edge.
- RUN:
  - in_ready=0.
  - Each cycle computes {borrow', d} = a_digit - b_digit - borrow on the low DIGIT_W bits, starting with borrow=bin.
  - d shifts into the result register from the MSB end; operands shift right by DIGIT_W.
  - counter increments each cycle. After the cycle with counter==N-1, go to DONE.
- DONE entry (same edge as the last RUN cycle):
  - diff, bout and ovf load from the internal result.
  - ovf = (a[DATA_W-1] != b[DATA_W-1]) & (diff[DATA_W-1] != a[DATA_W-1]), using the captured operands.
  - out_valid=1.
- DONE:
  - out_valid, diff, bout and ovf hold stable while out_ready=0.
  - On out_valid & out_ready: out_valid=0; go to IDLE; in_ready=1 on the next cycle.
- Latency: out_valid rises N rising edges after the accepting edge (4 at defaults). Throughput is one operation per N+2 cycles with out_ready tied high.
- in_valid is ignored outside IDLE: no capture, no error. in_ready is combinational from state only, never from in_valid.
- diff, bout and ovf retain the last result after the output handshake until the next DONE entry overwrites them.
- Result register width is exactly DATA_W; no extension bits are exposed.
- Boundary cases:
  - a == b with bin=1 gives all-ones diff and bout=1.
  - Minimum-negative minus a positive value sets ovf.
  - out_ready held high in IDLE or RUN has no effect.
  - The N-1 to 0 counter wrap occurs only on the RUN-to-DONE transition.

Test Plan:
- Reset: hold rst_n=0, toggle inputs -> in_ready=1, out_valid=0, diff=0x0000, bout=0, ovf=0, busy=0. Assert rst_n mid-RUN -> same values immediately, no out_valid afterwards.
- a=0x1234, b=0x0234, bin=0, out_ready=1 -> out_valid exactly 4 edges after accept; diff=0x1000, bout=0, ovf=0; in_ready back to 1 one cycle after the result handshake.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. Then a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1, ovf=0.
- a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1. Then a=0x7FFF, b=0xFFFF, bin=0 -> diff=0x8000, bout=1, ovf=1.
- Backpressure: result ready, out_ready=0 for 10 cycles while in_valid pulses with new operands -> out_valid and diff held stable, in_ready=0, no capture. Then out_ready=1 -> one handshake, IDLE next cycle.
- Random back-to-back: 1000 random a/b/bin with random out_ready -> every result matches a - b - bin modulo 2^16, with bout and ovf matching a reference model; results arrive in order, none dropped or duplicated.
